pm_loader: RTL and testbench

Program-memory loader: the write side of the 16-bit × 32-word program memory that the PC/ID path reads. It accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and drives a one-cycle write strobe with an auto-incrementing address. The CPU is held in stall while a load is in progress. It sits between the host link (UART/debug byte source) and the program memory write port.

---
 rtl/pm_loader_if.sv | 36 +++
 rtl/pm_loader.sv | 132 +++++++++++++
 tb/tb_pm_loader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pm_loader_if.sv
// Host-to-loader byte stream and loader-to-program-memory write bus.
//
// The master side is the host link. It drives start, byte_in and byte_valid.
// The slave side is pm_loader. It drives:
//   byte_ready - the loader takes a byte this cycle
//   pm_we      - one-cycle write strobe
//   pm_waddr   - write address
//   pm_wdata   - write data
//   cpu_hold   - stall request while a load runs
//   done       - load finished
//   err        - checksum failed on the last load
interface pm_loader_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 5
) ();
    logic                  start;
    logic [7:0]            byte_in;
    logic                  byte_valid;
    logic                  byte_ready;
    logic                  pm_we;
    logic [ADDR_WIDTH-1:0] pm_waddr;
    logic [DATA_WIDTH-1:0] pm_wdata;
    logic                  cpu_hold;
    logic                  done;
    logic                  err;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, pm_we, pm_waddr, pm_wdata, cpu_hold, done, err
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, pm_we, pm_waddr, pm_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/pm_loader.sv
// Program-memory loader.
//
// The loader takes a big-endian byte stream and builds 16-bit words from it.
// Each word is written to an auto-incrementing address of the program memory.
// The CPU is held in stall while a load runs.
//
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - pm_loader_if.slave, carrying the byte stream and the write port
//
// Optional feature, macro PM_LOADER_CHECKSUM_EN:
//   After the last word, one more byte is accepted.
//   This byte is compared with the XOR of all data bytes in the load.
//   A mismatch sets err. Without the macro, err is tied low.
//
// All outputs come from registers or are decoded from state only.
// No input reaches an output combinationally.
module pm_loader #(
    parameter int unsigned DATA_WIDTH = 16,  // must be 16: two bytes per word
    parameter int unsigned ADDR_WIDTH = 5
) (
    input logic        clk,
    input logic        rst_n,
    pm_loader_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StHi,
        StLo,
        StWr,
        StChk,
        StDone
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  done_q;
    logic                  hs;

`ifdef PM_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;
    logic       err_q;
`endif

    // byte_ready is state-decoded, so the handshake itself is safe to use in next-state logic.
    assign hs = bus.byte_valid && bus.byte_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
`ifdef PM_LOADER_CHECKSUM_EN
            csum_q  <= 8'h00;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (bus.start) begin
                        state_q <= StHi;
                        waddr_q <= '0;
                        done_q  <= 1'b0;
`ifdef PM_LOADER_CHECKSUM_EN
                        csum_q  <= 8'h00;
                        err_q   <= 1'b0;
`endif
                    end
                end
                StHi: begin
                    if (hs) begin
                        wdata_q[DATA_WIDTH-1 -: 8] <= bus.byte_in;
`ifdef PM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ bus.byte_in;
`endif
                        state_q <= StLo;
                    end
                end
                StLo: begin
                    if (hs) begin
                        wdata_q[7:0] <= bus.byte_in;
`ifdef PM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ bus.byte_in;
`endif
                        state_q <= StWr;
                    end
                end
                StWr: begin
                    // The last word lands on the top address. The address never wraps inside a load.
                    if (waddr_q == '1) begin
`ifdef PM_LOADER_CHECKSUM_EN
                        state_q <= StChk;
`else
                        state_q <= StDone;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        waddr_q <= waddr_q + 1'b1;
                        state_q <= StHi;
                    end
                end
`ifdef PM_LOADER_CHECKSUM_EN
                StChk: begin
                    if (hs) begin
                        err_q   <= (bus.byte_in != csum_q);
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.byte_ready = (state_q == StHi) || (state_q == StLo) || (state_q == StChk);
    assign bus.pm_we      = (state_q == StWr);
    assign bus.cpu_hold   = (state_q != StIdle) && (state_q != StDone);
    assign bus.pm_waddr   = waddr_q;
    assign bus.pm_wdata   = wdata_q;
    assign bus.done       = done_q;
`ifdef PM_LOADER_CHECKSUM_EN
    assign bus.err        = err_q;
`else
    assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_pm_loader.sv
// Self-checking bench for pm_loader.
// The stimulus pushes each expected {address, word} into a queue.
// A monitor pops one entry and compares it on every write strobe.
module tb_pm_loader;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 5;
    localparam int unsigned WORDS = 1 << AW;
`ifdef PM_LOADER_CHECKSUM_EN
    localparam int unsigned EXTRA = 1;
`else
    localparam int unsigned EXTRA = 0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   hold_cnt;
    int   we_cnt;
    logic [AW+DW-1:0] exp_q[$];

    pm_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    pm_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pop on every write strobe.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cpu_hold) hold_cnt++;
            if (bus.pm_we) begin
                logic [AW+DW-1:0] e;
                we_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h with empty queue",
                             bus.pm_waddr, bus.pm_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("pm_write", {11'h0, bus.pm_waddr, bus.pm_wdata}, {11'h0, e});
                end
                chk("ready_in_wr", {31'h0, bus.byte_ready}, 32'h0);
`ifndef PM_LOADER_CHECKSUM_EN
                chk("err_tied_low", {31'h0, bus.err}, 32'h0);
`endif
            end
        end
    end

    // Called and returns at a negedge. Holds the byte until it has been accepted.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                bus.byte_valid = 1'b0;
                bus.byte_in    = 8'($urandom);
                @(negedge clk);
            end
        end
        bus.byte_valid = 1'b1;
        bus.byte_in    = b;
        n = 0;
        while (!bus.byte_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: ready 0 required 1");
        end
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {31'h0, bus.byte_ready}, 32'h0);
        chk({tag, "_we"},    {31'h0, bus.pm_we}, 32'h0);
        chk({tag, "_waddr"}, {27'h0, bus.pm_waddr}, 32'h0);
        chk({tag, "_wdata"}, {16'h0, bus.pm_wdata}, 32'h0);
        chk({tag, "_hold"},  {31'h0, bus.cpu_hold}, 32'h0);
        chk({tag, "_done"},  {31'h0, bus.done}, 32'h0);
        chk({tag, "_err"},   {31'h0, bus.err}, 32'h0);
    endtask

    // Runs one load.
    //   pulse_at: word at which start is pulsed again (-1 for none)
    //   abort_at: word at which reset is asserted (-1 for none)
    task automatic run_load(input bit gaps, input int pulse_at, input int abort_at,
                            input bit rnd, input bit bad_csum);
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] wb;
        logic [7:0] x;
        logic [AW-1:0] a;
        int n;
        x        = 8'h00;
        hold_cnt = 0;
        we_cnt   = 0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("hold_after_start",  {31'h0, bus.cpu_hold}, 32'h1);
        chk("ready_after_start", {31'h0, bus.byte_ready}, 32'h1);
        chk("done_cleared",      {31'h0, bus.done}, 32'h0);
        chk("err_cleared",       {31'h0, bus.err}, 32'h0);
        for (int w = 0; w < int'(WORDS); w++) begin
            wb = w[7:0];
            a  = wb[AW-1:0];
            hi = rnd ? 8'($urandom) : (8'h70 | {4'h0, wb[3:0]});
            lo = rnd ? 8'($urandom) : wb;
            exp_q.push_back({a, hi, lo});
            if (w == pulse_at) bus.start = 1'b1;
            send_byte(hi, gaps);
            bus.start = 1'b0;
            if (w == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("abort");
                exp_q.delete();
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (5) @(negedge clk);
                chk("abort_idle_ready", {31'h0, bus.byte_ready}, 32'h0);
                chk("abort_idle_waddr", {27'h0, bus.pm_waddr}, 32'h0);
                return;
            end
            send_byte(lo, gaps);
            x = x ^ hi ^ lo;
        end
`ifdef PM_LOADER_CHECKSUM_EN
        send_byte(bad_csum ? (x ^ 8'h01) : x, gaps);
`endif
        n = 0;
        while (!bus.done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("done_set",     {31'h0, bus.done}, 32'h1);
        chk("done_hold",    {31'h0, bus.cpu_hold}, 32'h0);
        chk("done_ready",   {31'h0, bus.byte_ready}, 32'h0);
`ifdef PM_LOADER_CHECKSUM_EN
        chk("done_err",     {31'h0, bus.err}, {31'h0, bad_csum});
`else
        chk("done_err",     {31'h0, bus.err}, 32'h0);
`endif
        chk("write_count",  we_cnt, WORDS);
        chk("queue_empty",  exp_q.size(), 32'h0);
        if (!gaps) chk("hold_cycles", hold_cnt, 3 * WORDS + EXTRA);
        repeat (3) @(negedge clk);
        chk("done_sticky",  {31'h0, bus.done}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        hold_cnt       = 0;
        we_cnt         = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.byte_in    = 8'h00;
        bus.byte_valid = 1'b0;
        #3;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // A valid byte with no START must not be accepted.
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'hA5;
        repeat (5) @(negedge clk);
        chk("idle_no_start_ready", {31'h0, bus.byte_ready}, 32'h0);
        chk("idle_no_start_hold",  {31'h0, bus.cpu_hold}, 32'h0);
        bus.byte_valid = 1'b0;

        run_load(1'b0, -1, -1, 1'b0, 1'b0);  // full-rate canonical pattern
        run_load(1'b1, 10, -1, 1'b1, 1'b0);  // backpressure, START pulsed mid-load
        run_load(1'b0, -1, 10, 1'b1, 1'b0);  // reset at word 10
        run_load(1'b0, -1, -1, 1'b0, 1'b1);  // restart at 0, corrupted checksum
        run_load(1'b1, -1, -1, 1'b1, 1'b0);  // START clears err, good checksum

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
